// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and sizing helper for the
// fetch stage (fetch_queue and its fetch_fifo).
package fetch_pkg;

    // Canonical NOP (addi x0, x0, 0) presented to decode when the queue is empty.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Fetch control state. FAULT is only reachable when FETCH_MISALIGN_EN is defined.
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous register FIFO with push, pop and flush.
// The head entry is read straight out of the storage registers.
// Flush has priority over push/pop; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    occ_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i && (occ_q != '0) && !flush_i;
    assign push_ok = push_i && !flush_i && ((occ_q != CW'(DEPTH)) || pop_ok);

    // Next pointer / occupancy values; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            occ_d = occ_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage write; contents are meaningless until occupancy says otherwise.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;
    assign empty_o = (occ_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction fetch stage.
// Issues sequential fetch requests under a credit rule (queue entries plus
// in-flight requests never exceed DEPTH), enqueues in-order memory responses
// tagged with their PC, and squashes in-flight responses after a redirect.
// Optional feature macro: FETCH_MISALIGN_EN -- a misaligned redirect target
// parks the stage in FAULT until an aligned redirect arrives. Without it the
// low two bits of the redirect target are forced to zero.
//
// Handshakes: the request port transfers when imem_req_valid_o && imem_req_ready_i
// in the same cycle; valid never depends on ready or redirect. The response port
// has no ready: every imem_rsp_valid_i cycle is consumed in request order. The
// decode port transfers when dec_valid_o && dec_ready_i.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_instr_o,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [XLEN-1:0] dec_pc4_o,
    output logic            fault_o
);

    localparam int CW = cnt_width(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   occ;
    logic            fifo_empty;
    logic [2*XLEN-1:0] fifo_head;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;

    logic [XLEN-1:0] redir_pc;
    logic [CW:0]     inflight;
    logic            req_fire;
    logic            rsp_discard;
    logic            enq;
    logic            deq;

`ifdef FETCH_MISALIGN_EN
    logic            redir_misaligned;
    assign redir_pc         = redirect_pc_i;
    assign redir_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
    assign redir_pc         = redirect_pc_i & ~XLEN'(3);
`endif

    // Credit check counts squashed requests too: their responses still arrive.
    assign inflight         = {1'b0, occ} + {1'b0, outst_q};
    assign imem_req_valid_o = (inflight < (CW+1)'(DEPTH)) && (state_q == RUN);
    assign imem_req_addr_o  = req_pc_q;

    assign req_fire    = imem_req_valid_o && imem_req_ready_i;
    assign rsp_discard = (drop_q != '0) || redirect_i;
    assign enq         = imem_rsp_valid_i && !rsp_discard;
    assign deq         = dec_valid_o && dec_ready_i;

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (enq),
        .push_data_i ({rsp_pc_q, imem_rsp_data_i}),
        .pop_i       (deq),
        .flush_i     (redirect_i),
        .head_o      (fifo_head),
        .occ_o       (occ),
        .empty_o     (fifo_empty)
    );

    assign head_pc    = fifo_head[2*XLEN-1:XLEN];
    assign head_instr = fifo_head[XLEN-1:0];

    // Empty queue (or FAULT) presents a NOP with zero PCs.
    assign dec_valid_o = !fifo_empty && (state_q == RUN);
    assign dec_instr_o = dec_valid_o ? head_instr : XLEN'(NOP_INSTR);
    assign dec_pc_o    = dec_valid_o ? head_pc : '0;
    assign dec_pc4_o   = dec_valid_o ? (head_pc + XLEN'(4)) : '0;

    // PC and in-flight bookkeeping; a redirect squashes everything still in flight,
    // including a request accepted in the same cycle.
    always_comb begin
        req_pc_d = req_pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q;
        outst_d  = outst_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
        if (redirect_i) begin
            req_pc_d = redir_pc;
            rsp_pc_d = redir_pc;
            drop_d   = outst_d;
        end else begin
            if (req_fire) req_pc_d = req_pc_q + XLEN'(4);
            if (enq)      rsp_pc_d = rsp_pc_q + XLEN'(4);
            if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            req_pc_q <= req_pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state: every redirect re-evaluates alignment of its target.
    always_comb begin
        state_d = state_q;
`ifdef FETCH_MISALIGN_EN
        if (redirect_i) begin
            state_d = redir_misaligned ? FAULT : RUN;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

`ifdef FETCH_MISALIGN_EN
    assign fault_o = (state_q == FAULT);
`else
    assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue with an in-order memory
// model and a queue-based reference of what decode should see.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic            clk;
    logic            rst_n;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;
    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [XLEN-1:0] dec_instr_o;
    logic [XLEN-1:0] dec_pc_o;
    logic [XLEN-1:0] dec_pc4_o;
    logic            fault_o;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .dec_valid_o      (dec_valid_o),
        .dec_ready_i      (dec_ready_i),
        .dec_instr_o      (dec_instr_o),
        .dec_pc_o         (dec_pc_o),
        .dec_pc4_o        (dec_pc4_o),
        .fault_o          (fault_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_fire = 0;

    logic [XLEN-1:0] exp_q[$];        // PCs decode should see, head first
    logic [XLEN-1:0] pend_addr[$];    // requests accepted by memory, in order
    bit              pend_stale[$];   // squashed by a later redirect
    int              pend_due[$];     // earliest response cycle
    logic [XLEN-1:0] exp_req_pc;
    bit              exp_fault;

    // stimulus policy
    int ready_pct = 100;
    int dec_pct   = 100;
    int lat_min   = 1;
    int lat_max   = 1;
    int redir_pm  = 0;
    bit              force_redir = 0;
    logic [XLEN-1:0] force_target = '0;

    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic bit exp_req_valid();
        return !exp_fault && ((exp_q.size() + pend_addr.size()) < DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic [XLEN-1:0] hpc;
        chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, exp_req_valid()});
        chk("req_addr", imem_req_addr_o, exp_req_pc);
        chk("dec_valid", {31'b0, dec_valid_o}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            hpc = exp_q[0];
            chk("dec_pc", dec_pc_o, hpc);
            chk("dec_instr", dec_instr_o, mem_word(hpc));
            chk("dec_pc4", dec_pc4_o, hpc + 32'd4);
        end else begin
            chk("dec_pc_empty", dec_pc_o, 32'h0);
            chk("dec_instr_empty", dec_instr_o, NOP);
            chk("dec_pc4_empty", dec_pc4_o, 32'h0);
        end
        chk("fault", {31'b0, fault_o}, {31'b0, exp_fault});
    endtask

    // Advance the reference by one cycle using this cycle's inputs.
    task automatic model_step();
        bit              fire;
        bit              deq;
        bit              st;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] tgt;
        fire = exp_req_valid() && imem_req_ready_i;
        deq  = (exp_q.size() != 0) && dec_ready_i;
        if (fire) n_fire++;
        if (deq) void'(exp_q.pop_front());
        if (imem_rsp_valid_i) begin
            a  = pend_addr.pop_front();
            st = pend_stale.pop_front();
            void'(pend_due.pop_front());
            if (!st && !redirect_i) exp_q.push_back(a);
        end
        if (fire) begin
            pend_addr.push_back(exp_req_pc);
            pend_stale.push_back(1'b0);
            pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (redirect_i) begin
`ifdef FETCH_MISALIGN_EN
            tgt       = redirect_pc_i;
            exp_fault = (redirect_pc_i[1:0] != 2'b00);
`else
            tgt       = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif
            exp_q.delete();
            foreach (pend_stale[k]) pend_stale[k] = 1'b1;
            exp_req_pc = tgt;
        end
    endtask

    task automatic reset_dut();
        rst_n            = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        dec_ready_i      = 1'b0;
        exp_q.delete();
        pend_addr.delete();
        pend_stale.delete();
        pend_due.delete();
        exp_req_pc = RESET_PC;
        exp_fault  = 1'b0;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        logic [XLEN-1:0] t;
        for (int i = 0; i < n; i++) begin
            imem_req_ready_i = ($urandom_range(99) < ready_pct);
            dec_ready_i      = ($urandom_range(99) < dec_pct);
            if (force_redir) begin
                redirect_i    = 1'b1;
                redirect_pc_i = force_target;
                force_redir   = 1'b0;
            end else if ($urandom_range(999) < redir_pm) begin
                t = $urandom;
                if ($urandom_range(9) != 0) t[1:0] = 2'b00;
                redirect_i    = 1'b1;
                redirect_pc_i = t;
            end else begin
                redirect_i    = 1'b0;
                redirect_pc_i = $urandom;
            end
            if (pend_addr.size() != 0 && cyc >= pend_due[0]) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = mem_word(pend_addr[0]);
            end else begin
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = $urandom;
            end
            @(negedge clk);
            check_outputs();
            model_step();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic redirect_then(input logic [XLEN-1:0] tgt, input int n);
        force_redir  = 1'b1;
        force_target = tgt;
        run_cycles(n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Sequential streaming with single-cycle memory, plus redirects that
        // coincide with a request handshake and a response, and a wrap of the PC.
        reset_dut();
        ready_pct = 100; dec_pct = 100; lat_min = 1; lat_max = 1; redir_pm = 0;
        run_cycles(20);
        redirect_then(32'h0000_0040, 12);
        redirect_then(32'hFFFF_FFF8, 12);

        // Decode stalled from reset: the credit limit caps accepted requests.
        reset_dut();
        dec_pct = 0; n_fire = 0;
        run_cycles(10);
        chk("stall_reqs", n_fire, DEPTH);
        dec_pct = 100;
        run_cycles(10);

        // Three-cycle memory with requests in flight, then a redirect.
        reset_dut();
        lat_min = 3; lat_max = 3;
        run_cycles(6);
        redirect_then(32'h0000_0100, 16);

        // Misaligned redirect then an aligned one.
        lat_min = 1; lat_max = 2;
        redirect_then(32'h0000_0102, 10);
        redirect_then(32'h0000_0200, 12);

        // Long randomized run with back-pressure, variable latency and redirects.
        ready_pct = 60; dec_pct = 70; lat_min = 1; lat_max = 4; redir_pm = 25;
        run_cycles(1000);

        // Reset in the middle of traffic, then a short random run.
        reset_dut();
        run_cycles(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
